// File: rtl/vga_pixel_pipe.sv
// Pixel back-end: registers the picture-memory address, realigns sideband with the memory data,
// applies the optional darkness mask (`DARK_MASK_EN`) and a frame-paced fade-in.
`timescale 1ns / 1ps
module vga_pixel_pipe #(
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned FADE_FRAMES = 4,
  parameter int unsigned DARK_RADIUS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [16:0] pixel_addr,
  input  logic        notBlank,
  input  logic [3:0]  state,
  input  logic        isDark,
  input  logic [8:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic [11:0] rom_data,
  output logic [16:0] rom_addr,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned CntW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CntW-1:0] FadeLast = CntW'(FADE_FRAMES - 1);

  typedef struct packed {
    logic valid;
    logic nb;
    logic hs;
    logic vs;
    logic kill;
  } sb_t;

  localparam sb_t SbReset = '{valid: 1'b0, nb: 1'b0, hs: 1'b1, vs: 1'b1, kill: 1'b0};

  typedef enum logic [0:0] {StFading, StBright} fade_state_e;

  logic kill_a;

`ifdef DARK_MASK_EN
  logic signed [9:0] dx;
  logic signed [9:0] dy;
  logic [9:0]        ax;
  logic [9:0]        ay;
  logic [10:0]       dist;
  logic              dark_hit;
  logic              dark_active;

  // Screen coordinates are 640x480; the player lives on the halved 320x240 grid.
  always_comb begin
    dx          = $signed({1'b0, h_cnt[9:1]}) - $signed({1'b0, player_x});
    dy          = $signed({1'b0, v_cnt[9:1]}) - $signed({1'b0, player_y});
    ax          = dx[9] ? $unsigned(-dx) : $unsigned(dx);
    ay          = dy[9] ? $unsigned(-dy) : $unsigned(dy);
    dist        = {1'b0, ax} + {1'b0, ay};
    dark_hit    = dist > 11'(DARK_RADIUS);
    dark_active = isDark && (state == 4'd2 || state == 4'd4 || state == 4'd6);
  end

  assign kill_a = dark_active && dark_hit;
`else
  logic unused_dark;
  assign unused_dark = ^{isDark, player_x, player_y};
  assign kill_a      = 1'b0;
`endif

  // Stage A plus ROM_LAT delay stages, so sideband meets rom_data at stage C.
  sb_t sb_a;
  sb_t sb_q [ROM_LAT+1];
  sb_t sb_c;

  assign sb_a = '{valid: valid, nb: notBlank, hs: hsync_in, vs: vsync_in, kill: kill_a};
  assign sb_c = sb_q[ROM_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_addr <= '0;
      for (int i = 0; i <= int'(ROM_LAT); i++) sb_q[i] <= SbReset;
    end else begin
      rom_addr <= pixel_addr;
      sb_q[0]  <= sb_a;
      for (int i = 1; i <= int'(ROM_LAT); i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // Fade FSM
  fade_state_e     fade_q, fade_d;
  logic [4:0]      level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      prev_state_q;
  logic            frame_tick;
  logic            state_chg;
  logic            cnt_en;
  logic            lvl_inc;

  assign frame_tick = (h_cnt == 10'd0) && (v_cnt == 10'd480);
  assign state_chg  = (state != prev_state_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fade_q       <= StFading;
      level_q      <= '0;
      cnt_q        <= '0;
      prev_state_q <= '0;
    end else begin
      fade_q       <= fade_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      prev_state_q <= state;
    end
  end

  // A state change overrides any tick in the same cycle.
  always_comb begin
    fade_d  = fade_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (state_chg) begin
      fade_d  = StFading;
      level_d = '0;
      cnt_d   = '0;
    end else if (cnt_en) begin
      if (lvl_inc) begin
        cnt_d   = '0;
        level_d = level_q + 5'd1;
        if (level_q == 5'd15) fade_d = StBright;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    cnt_en  = 1'b0;
    lvl_inc = 1'b0;
    if (fade_q == StFading && frame_tick && !state_chg) begin
      cnt_en  = 1'b1;
      lvl_inc = (cnt_q == FadeLast);
    end
  end

  // Stage C
  logic [7:0] prod_r, prod_g, prod_b;
  logic [3:0] red_d, green_d, blue_d;

  always_comb begin
    prod_r  = 8'(rom_data[11:8]) * 8'(level_q);
    prod_g  = 8'(rom_data[7:4]) * 8'(level_q);
    prod_b  = 8'(rom_data[3:0]) * 8'(level_q);
    red_d   = prod_r[7:4];
    green_d = prod_g[7:4];
    blue_d  = prod_b[7:4];
    if (!sb_c.valid || !sb_c.nb || sb_c.kill) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vgaRed   <= '0;
      vgaGreen <= '0;
      vgaBlue  <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      vgaRed   <= red_d;
      vgaGreen <= green_d;
      vgaBlue  <= blue_d;
      hsync    <= sb_c.hs;
      vsync    <= sb_c.vs;
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: pixel-level behavioural model checked every cycle, plus literal pins
// for reset, latency, blanking, darkness and fade timing.
`timescale 1ns / 1ps
module tb_vga_pixel_pipe;

  localparam int unsigned RomLat     = 1;
  localparam int unsigned FadeFrames = 4;
  localparam int unsigned DarkRadius = 40;
`ifdef DARK_MASK_EN
  localparam bit DarkEn = 1'b1;
`else
  localparam bit DarkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid, hsync_in, vsync_in, notBlank, isDark;
  logic [16:0] pixel_addr, rom_addr;
  logic [3:0]  state;
  logic [8:0]  player_x, player_y;
  logic [11:0] rom_data;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;
  logic        hsync, vsync;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_pixel_pipe #(
    .ROM_LAT    (RomLat),
    .FADE_FRAMES(FadeFrames),
    .DARK_RADIUS(DarkRadius)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .valid     (valid),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .pixel_addr(pixel_addr),
    .notBlank  (notBlank),
    .state     (state),
    .isDark    (isDark),
    .player_x  (player_x),
    .player_y  (player_y),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .vgaRed    (vgaRed),
    .vgaGreen  (vgaGreen),
    .vgaBlue   (vgaBlue),
    .hsync     (hsync),
    .vsync     (vsync)
  );

  // Picture memory contents: 0x123 -> ABC, 0x666 -> FFF, 0x000 -> 999.
  function automatic logic [11:0] rom_fn(input logic [16:0] a);
    return a[11:0] + 12'h999;
  endfunction

  logic [11:0] rd_pipe [RomLat];
  always @(posedge clk) begin
    rd_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < int'(RomLat); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rom_data = rd_pipe[RomLat-1];

  // ---------------- model ----------------
  typedef struct {
    logic        v;
    logic        nb;
    logic        kill;
    logic        hs;
    logic        vs;
    logic [11:0] col;
  } rec_t;

  rec_t q[$];
  logic [11:0] exp_rgb  = '0;
  logic        exp_hs   = 1'b1;
  logic        exp_vs   = 1'b1;
  logic [16:0] exp_addr = '0;
  int          ticks    = 0;
  logic [3:0]  prev_st  = '0;

  function automatic int fade_level(input int t);
    int l;
    l = t / int'(FadeFrames);
    return (l > 16) ? 16 : l;
  endfunction

  function automatic logic [11:0] shade(input rec_t r, input int lvl);
    if (!r.v || !r.nb || r.kill) return 12'h000;
    return {4'((int'(r.col[11:8]) * lvl) / 16), 4'((int'(r.col[7:4]) * lvl) / 16),
            4'((int'(r.col[3:0]) * lvl) / 16)};
  endfunction

  function automatic logic is_dark_pixel(input logic [9:0] h, input logic [9:0] v,
                                         input logic [8:0] px, input logic [8:0] py,
                                         input logic dk, input logic [3:0] st);
    int dx, dy;
    dx = int'(h >> 1) - int'(px);
    dy = int'(v >> 1) - int'(py);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return DarkEn && dk && (st == 4'd2 || st == 4'd4 || st == 4'd6) &&
           (dx + dy > int'(DarkRadius));
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      for (int i = 0; i <= int'(RomLat); i++)
        q.push_back('{v: 1'b0, nb: 1'b0, kill: 1'b0, hs: 1'b1, vs: 1'b1, col: 12'h000});
      exp_rgb  <= '0;
      exp_hs   <= 1'b1;
      exp_vs   <= 1'b1;
      exp_addr <= '0;
      ticks    <= 0;
      prev_st  <= '0;
    end else begin
      exp_rgb  <= shade(q[0], fade_level(ticks));
      exp_hs   <= q[0].hs;
      exp_vs   <= q[0].vs;
      exp_addr <= pixel_addr;
      void'(q.pop_front());
      q.push_back('{v: valid, nb: notBlank, hs: hsync_in, vs: vsync_in, col: rom_fn(pixel_addr),
                    kill: is_dark_pixel(h_cnt, v_cnt, player_x, player_y, isDark, state)});
      ticks    <= (state != prev_st) ? 0 :
                  ((h_cnt == 10'd0 && v_cnt == 10'd480 && ticks < 1000) ? ticks + 1 : ticks);
      prev_st  <= state;
    end
  end

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_rgb", 17'({vgaRed, vgaGreen, vgaBlue}), 17'(exp_rgb));
      check("model_hsync", 17'(hsync), 17'(exp_hs));
      check("model_vsync", 17'(vsync), 17'(exp_vs));
      check("model_rom_addr", rom_addr, exp_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      h_cnt = 10'd0;
      v_cnt = 10'd480;
      @(negedge clk);
      h_cnt = 10'd1;
      v_cnt = 10'd0;
      @(negedge clk);
    end
  endtask

  task automatic lit_rgb(input string name, input logic [11:0] exp);
    check(name, 17'({vgaRed, vgaGreen, vgaBlue}), 17'(exp));
  endtask

  task automatic dark_probe(input string name, input logic [9:0] h, input logic [9:0] v,
                            input bit pass);
    h_cnt      = h;
    v_cnt      = v;
    pixel_addr = 17'h00123;
    wait_n(3);
    lit_rgb(name, pass ? 12'hABC : 12'h000);
  endtask

  initial begin
    rst = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; valid = 1'b1; notBlank = 1'b1;
    pixel_addr = 17'h00666; h_cnt = 10'd1; v_cnt = 10'd0; state = 4'd0; isDark = 1'b0;
    player_x = 9'd100; player_y = 9'd100;
    wait_n(5);
    lit_rgb("rst_rgb", 12'h000);
    check("rst_hsync", 17'(hsync), 17'd1);
    check("rst_vsync", 17'(vsync), 17'd1);
    check("rst_rom_addr", rom_addr, 17'h0);
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    wait_n(4);
    lit_rgb("fade_lvl0", 12'h000);
    tick_n(32);
    wait_n(4);
    lit_rgb("fade_lvl8", 12'h777);
    tick_n(32);
    wait_n(4);
    lit_rgb("fade_lvl16", 12'hFFF);

    // Latency and sync alignment
    pixel_addr = 17'h00123; hsync_in = 1'b0;
    wait_n(1);
    check("lat_rom_addr", rom_addr, 17'h00123);
    pixel_addr = 17'h00000; hsync_in = 1'b1;
    wait_n(1);
    lit_rgb("lat_rgb_early", 12'hFFF);
    check("lat_hsync_early", 17'(hsync), 17'd1);
    wait_n(1);
    lit_rgb("lat_rgb", 12'hABC);
    check("lat_hsync", 17'(hsync), 17'd0);
    wait_n(1);
    lit_rgb("lat_rgb_next", 12'h999);
    check("lat_hsync_next", 17'(hsync), 17'd1);

    // Blanking
    pixel_addr = 17'h00666; valid = 1'b0;
    wait_n(1);
    valid = 1'b1; notBlank = 1'b0;
    wait_n(1);
    notBlank = 1'b1;
    wait_n(1);
    lit_rgb("blank_valid", 12'h000);
    wait_n(1);
    lit_rgb("blank_notblank", 12'h000);
    wait_n(1);
    lit_rgb("blank_restore", 12'hFFF);

    // Darkness: title state never masks
    isDark = 1'b1;
    dark_probe("dark_st0_near", 10'd200, 10'd200, 1'b1);
    dark_probe("dark_st0_far", 10'd282, 10'd200, 1'b1);
    state = 4'd2; h_cnt = 10'd1; v_cnt = 10'd0;
    wait_n(1);
    tick_n(64);
    dark_probe("dark_st2_d0", 10'd200, 10'd200, 1'b1);
    dark_probe("dark_st2_d40", 10'd280, 10'd200, 1'b1);
    dark_probe("dark_st2_d41", 10'd282, 10'd200, !DarkEn);
    dark_probe("dark_st2_d41_neg", 10'd118, 10'd200, !DarkEn);
    dark_probe("dark_st2_d40_vert", 10'd200, 10'd120, 1'b1);
    isDark = 1'b0;
    dark_probe("dark_off_d41", 10'd282, 10'd200, 1'b1);

    // Fade restart
    h_cnt = 10'd1; v_cnt = 10'd0; pixel_addr = 17'h00666;
    wait_n(3);
    state = 4'd3;
    wait_n(1);
    lit_rgb("restart_prev", 12'hFFF);
    wait_n(1);
    lit_rgb("restart_lvl0", 12'h000);
    tick_n(4);
    wait_n(4);
    lit_rgb("restart_lvl1", 12'h000);
    tick_n(28);
    wait_n(4);
    lit_rgb("restart_lvl8", 12'h777);
    // State change coinciding with a tick: the tick must not count
    state = 4'd2; h_cnt = 10'd0; v_cnt = 10'd480;
    wait_n(1);
    h_cnt = 10'd1; v_cnt = 10'd0;
    wait_n(1);
    tick_n(7);
    wait_n(4);
    lit_rgb("tie_lvl1", 12'h000);
    tick_n(1);
    wait_n(4);
    lit_rgb("tie_lvl2", 12'h111);

    // Mid-operation reset
    rst = 1'b0; hsync_in = 1'b0;
    wait_n(2);
    lit_rgb("mid_rst_rgb", 12'h000);
    check("mid_rst_hsync", 17'(hsync), 17'd1);
    rst = 1'b1; hsync_in = 1'b1; state = 4'd0;
    wait_n(5);
    lit_rgb("mid_rst_lvl0", 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
